// File: rtl/io_frame_pkg.sv
// Register map and window constants shared by the I/O frame bridge.
// No logic of its own; latency and backpressure are defined by the users of these constants.
package io_frame_pkg;

  localparam int OFF_W     = 5;
  localparam int IO_WINDOW = 32'h20;

  localparam logic [OFF_W-1:0] OFF_BTN_LEVEL   = 5'h00;
  localparam logic [OFF_W-1:0] OFF_BTN_PRESS   = 5'h01;
  localparam logic [OFF_W-1:0] OFF_FRAME_CNT   = 5'h02;
  localparam logic [OFF_W-1:0] OFF_CTRL        = 5'h03;
  localparam logic [OFF_W-1:0] OFF_SPRITE_BASE = 5'h10;

  localparam int CTRL_COMMIT_EN = 0;

  // Sprite i owns an x/y register pair at OFF_SPRITE_BASE + 2i (+1 for y).
  function automatic logic [OFF_W-1:0] sprite_off(input int idx, input logic is_y);
    return OFF_SPRITE_BASE + OFF_W'(2 * idx) + OFF_W'(is_y);
  endfunction

endpackage

// File: rtl/btn_debounce.sv
// Single-button 2-flop synchroniser plus debounce counter and level register.
// Level follows the synced input after DEBOUNCE_CYC stable cycles; no backpressure.
module btn_debounce #(
  parameter int DEBOUNCE_CYC = 500000
) (
  input  logic clock,
  input  logic reset,
  input  logic btn,
  output logic level,
  output logic rise
);

  localparam int CNT_W = ($clog2(DEBOUNCE_CYC) > 0) ? $clog2(DEBOUNCE_CYC) : 1;

  logic             sync0;
  logic             sync1;
  logic [CNT_W-1:0] cnt;
  logic             toggle;

  assign toggle = (sync1 != level) && (cnt == CNT_W'(DEBOUNCE_CYC - 1));
  // Pulses in the cycle whose clock edge raises the level.
  assign rise   = toggle && !level;

  always_ff @(posedge clock) begin
    if (reset) begin
      sync0 <= 1'b0;
      sync1 <= 1'b0;
      cnt   <= '0;
      level <= 1'b0;
    end else begin
      sync0 <= btn;
      sync1 <= sync0;
      if (sync1 == level) begin
        cnt <= '0;
      end else if (toggle) begin
        level <= ~level;
        cnt   <= '0;
      end else begin
        cnt <= cnt + CNT_W'(1);
      end
    end
  end

endmodule

// File: rtl/io_frame_bridge.sv
// Memory-mapped bridge: double-buffered sprite coordinates, debounced buttons, frame counter.
// Reads return one cycle after the access; stores take effect immediately; no backpressure.
module io_frame_bridge
  import io_frame_pkg::*;
#(
  parameter int                NUM_SPRITES  = 4,
  parameter int                COORD_W      = 10,
  parameter int                NUM_BTN      = 2,
  parameter int                DEBOUNCE_CYC = 500000,
  parameter int                ADDR_W       = 12,
  parameter logic [ADDR_W-1:0] BASE_ADDR    = 12'hF00
) (
  input  logic                           clock,
  input  logic                           reset,
  input  logic                           wren,
  input  logic                           ren,
  input  logic [ADDR_W-1:0]              address_dmem,
  input  logic [31:0]                    data,
  output logic                           io_hit,
  output logic [31:0]                    q_io,
  input  logic                           screen_end,
  input  logic [NUM_BTN-1:0]             btn,
  output logic [NUM_SPRITES*COORD_W-1:0] sprite_x_flat,
  output logic [NUM_SPRITES*COORD_W-1:0] sprite_y_flat
);

  logic [ADDR_W-1:0]  offset;
  logic [OFF_W-1:0]   off;
  logic               sel;
  logic               wr_sel;
  logic               rd_sel;
  logic               screen_end_d;
  logic               frame_edge;
  logic               commit_en;
  logic [31:0]        frame_cnt;
  logic [31:0]        rd_data;
  logic [NUM_BTN-1:0] btn_level;
  logic [NUM_BTN-1:0] btn_rise;
  logic [NUM_BTN-1:0] btn_press;
  logic               unused_data;

  logic [COORD_W-1:0] shadow_x [NUM_SPRITES];
  logic [COORD_W-1:0] shadow_y [NUM_SPRITES];
  logic [COORD_W-1:0] active_x [NUM_SPRITES];
  logic [COORD_W-1:0] active_y [NUM_SPRITES];

  // Addresses below the base wrap to large offsets and fall outside the window.
  assign offset      = address_dmem - BASE_ADDR;
  assign sel         = offset < ADDR_W'(IO_WINDOW);
  assign off         = offset[OFF_W-1:0];
  assign wr_sel      = wren && sel;
  assign rd_sel      = ren && sel;
  assign frame_edge  = screen_end && !screen_end_d;
  assign unused_data = ^data[31:COORD_W];

  for (genvar g = 0; g < NUM_BTN; g++) begin : g_btn
    btn_debounce #(
      .DEBOUNCE_CYC(DEBOUNCE_CYC)
    ) u_btn_debounce (
      .clock(clock),
      .reset(reset),
      .btn  (btn[g]),
      .level(btn_level[g]),
      .rise (btn_rise[g])
    );
  end

  for (genvar g = 0; g < NUM_SPRITES; g++) begin : g_flat
    assign sprite_x_flat[g*COORD_W +: COORD_W] = active_x[g];
    assign sprite_y_flat[g*COORD_W +: COORD_W] = active_y[g];
  end

  always_comb begin
    rd_data = '0;
    case (off)
      OFF_BTN_LEVEL: rd_data = 32'(btn_level);
      OFF_BTN_PRESS: rd_data = 32'(btn_press);
      OFF_FRAME_CNT: rd_data = frame_cnt;
      OFF_CTRL:      rd_data = 32'(commit_en);
      default:       rd_data = '0;
    endcase
    for (int i = 0; i < NUM_SPRITES; i++) begin
      if (off == sprite_off(i, 1'b0)) rd_data = 32'(shadow_x[i]);
      if (off == sprite_off(i, 1'b1)) rd_data = 32'(shadow_y[i]);
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      for (int i = 0; i < NUM_SPRITES; i++) begin
        shadow_x[i] <= '0;
        shadow_y[i] <= '0;
        active_x[i] <= '0;
        active_y[i] <= '0;
      end
      screen_end_d <= 1'b0;
      commit_en    <= 1'b1;
      frame_cnt    <= '0;
      btn_press    <= '0;
      io_hit       <= 1'b0;
      q_io         <= '0;
    end else begin
      screen_end_d <= screen_end;
      io_hit       <= rd_sel;
      q_io         <= rd_sel ? rd_data : 32'd0;

      if (frame_edge) frame_cnt <= frame_cnt + 32'd1;

      // Commit reads the registered shadow, so a same-cycle store lands next frame.
      if (frame_edge && commit_en) begin
        for (int i = 0; i < NUM_SPRITES; i++) begin
          active_x[i] <= shadow_x[i];
          active_y[i] <= shadow_y[i];
        end
      end

      if (wr_sel) begin
        if (off == OFF_CTRL) commit_en <= data[CTRL_COMMIT_EN];
        for (int i = 0; i < NUM_SPRITES; i++) begin
          if (off == sprite_off(i, 1'b0)) shadow_x[i] <= data[COORD_W-1:0];
          if (off == sprite_off(i, 1'b1)) shadow_y[i] <= data[COORD_W-1:0];
        end
      end

      // A fresh debounced rise beats a same-cycle read-clear.
      btn_press <= ((rd_sel && off == OFF_BTN_PRESS) ? '0 : btn_press) | btn_rise;
    end
  end

endmodule

// File: tb/tb_io_frame_bridge.sv
// Directed bench for io_frame_bridge with a register-level reference model and literal spot checks.
module tb_io_frame_bridge;

  localparam int NS  = 4;
  localparam int CW  = 10;
  localparam int NB  = 2;
  localparam int DEB = 4;

  logic              clock = 1'b0;
  logic              reset;
  logic              wren;
  logic              ren;
  logic [11:0]       address_dmem;
  logic [31:0]       data;
  logic              io_hit;
  logic [31:0]       q_io;
  logic              screen_end;
  logic [NB-1:0]     btn;
  logic [NS*CW-1:0]  sprite_x_flat;
  logic [NS*CW-1:0]  sprite_y_flat;

  io_frame_bridge #(
    .NUM_SPRITES (NS),
    .COORD_W     (CW),
    .NUM_BTN     (NB),
    .DEBOUNCE_CYC(DEB),
    .ADDR_W      (12),
    .BASE_ADDR   (12'hF00)
  ) dut (
    .clock        (clock),
    .reset        (reset),
    .wren         (wren),
    .ren          (ren),
    .address_dmem (address_dmem),
    .data         (data),
    .io_hit       (io_hit),
    .q_io         (q_io),
    .screen_end   (screen_end),
    .btn          (btn),
    .sprite_x_flat(sprite_x_flat),
    .sprite_y_flat(sprite_y_flat)
  );

  always #5 clock = ~clock;

  int checks   = 0;
  int failures = 0;
  bit chk_en   = 0;

  // Reference model state, expressed in register-map terms.
  logic [CW-1:0] m_sx [NS];
  logic [CW-1:0] m_sy [NS];
  logic [CW-1:0] m_ax [NS];
  logic [CW-1:0] m_ay [NS];
  logic [31:0]   m_fcnt;
  logic          m_ctrl;
  logic          m_se_prev;
  logic          m_hit;
  logic [31:0]   m_q;
  int            m_lvl   [NB];
  int            m_press [NB];
  int            m_sync0 [NB];
  int            m_sync1 [NB];
  int            m_stable[NB];

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=0x%0h exp=0x%0h", name, got, exp);
    end
  endtask

  function automatic logic [31:0] m_read(input int off);
    logic [31:0] v;
    v = 32'd0;
    if (off == 0) for (int b = 0; b < NB; b++) v[b] = m_lvl[b][0];
    if (off == 1) for (int b = 0; b < NB; b++) v[b] = m_press[b][0];
    if (off == 2) v = m_fcnt;
    if (off == 3) v = {31'd0, m_ctrl};
    if (off >= 16 && off < 16 + 2 * NS)
      v = (off % 2 == 0) ? 32'(m_sx[(off - 16) / 2]) : 32'(m_sy[(off - 16) / 2]);
    return v;
  endfunction

  // One clock: wait for the edge, then advance the model with the inputs it saw.
  task automatic tick();
    int off;
    bit inwin;
    bit fe;
    @(posedge clock);
    off   = int'(address_dmem) - 32'hF00;
    inwin = (off >= 0) && (off < 32);
    if (reset) begin
      for (int i = 0; i < NS; i++) begin
        m_sx[i] = '0; m_sy[i] = '0; m_ax[i] = '0; m_ay[i] = '0;
      end
      for (int b = 0; b < NB; b++) begin
        m_lvl[b] = 0; m_press[b] = 0; m_sync0[b] = 0; m_sync1[b] = 0; m_stable[b] = 0;
      end
      m_fcnt = '0; m_ctrl = 1'b1; m_se_prev = 1'b0; m_hit = 1'b0; m_q = '0;
    end else begin
      m_hit = ren && inwin;
      m_q   = m_hit ? m_read(off) : 32'd0;
      fe = screen_end && !m_se_prev;
      m_se_prev = screen_end;
      if (fe) begin
        m_fcnt = m_fcnt + 32'd1;
        if (m_ctrl) for (int i = 0; i < NS; i++) begin
          m_ax[i] = m_sx[i]; m_ay[i] = m_sy[i];
        end
      end
      if (wren && inwin) begin
        if (off == 3) m_ctrl = data[0];
        if (off >= 16 && off < 16 + 2 * NS) begin
          if (off % 2 == 0) m_sx[(off - 16) / 2] = data[CW-1:0];
          else              m_sy[(off - 16) / 2] = data[CW-1:0];
        end
      end
      if (ren && inwin && off == 1) for (int b = 0; b < NB; b++) m_press[b] = 0;
      // Level flips after DEB consecutive cycles of the synced input disagreeing with it.
      for (int b = 0; b < NB; b++) begin
        if (m_sync1[b] != m_lvl[b]) begin
          m_stable[b]++;
          if (m_stable[b] == DEB) begin
            m_lvl[b]    = 1 - m_lvl[b];
            m_stable[b] = 0;
            if (m_lvl[b] == 1) m_press[b] = 1;
          end
        end else begin
          m_stable[b] = 0;
        end
        m_sync1[b] = m_sync0[b];
        m_sync0[b] = int'(btn[b]);
      end
    end
    #1;
  endtask

  always @(negedge clock) begin : cmp
    logic [NS*CW-1:0] ex;
    logic [NS*CW-1:0] ey;
    if (chk_en) begin
      for (int i = 0; i < NS; i++) begin
        ex[i*CW +: CW] = m_ax[i];
        ey[i*CW +: CW] = m_ay[i];
      end
      check("io_hit", 64'(io_hit), 64'(m_hit));
      check("q_io", 64'(q_io), 64'(m_q));
      check("sprite_x_flat", 64'(sprite_x_flat), 64'(ex));
      check("sprite_y_flat", 64'(sprite_y_flat), 64'(ey));
    end
  end

  task automatic idle(input int n);
    repeat (n) tick();
  endtask

  task automatic wr(input logic [11:0] a, input logic [31:0] d);
    address_dmem = a; data = d; wren = 1'b1;
    tick();
    wren = 1'b0;
  endtask

  task automatic rd(input logic [11:0] a);
    address_dmem = a; ren = 1'b1;
    tick();
    ren = 1'b0;
  endtask

  task automatic pulse();
    screen_end = 1'b1;
    tick();
    screen_end = 1'b0;
    tick();
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog timeout checks=%0d", checks);
    $fatal(1);
  end

  initial begin
    reset = 1'b1; wren = 1'b0; ren = 1'b0; screen_end = 1'b0;
    btn = '0; address_dmem = '0; data = '0;
    tick();
    chk_en = 1;
    tick();
    reset = 1'b0;
    check("rst_q_io", 64'(q_io), 64'h0);
    check("rst_io_hit", 64'(io_hit), 64'h0);
    check("rst_sprite_x", 64'(sprite_x_flat), 64'h0);

    // Shadow stores stay invisible until a frame edge.
    wr(12'hF10, 32'h3FF);
    wr(12'hF11, 32'h123);
    idle(2);
    check("no_commit_x", 64'(sprite_x_flat), 64'h0);
    pulse();
    check("commit_x0", 64'(sprite_x_flat[9:0]), 64'h3FF);
    check("commit_y0", 64'(sprite_y_flat[9:0]), 64'h123);
    rd(12'hF10);
    check("rd_x0", 64'(q_io), 64'h3FF);
    check("rd_x0_hit", 64'(io_hit), 64'h1);
    tick();

    // Truncation, unmapped offset, out-of-window address.
    wr(12'hF12, 32'h7FF);
    rd(12'hF12);
    check("trunc_x1", 64'(q_io), 64'h3FF);
    wr(12'hF1F, 32'h55);
    rd(12'hF1F);
    check("unmapped_rd", 64'(q_io), 64'h0);
    rd(12'hEFF);
    check("below_base_hit", 64'(io_hit), 64'h0);

    // Glitches shorter than the debounce window are ignored.
    btn = 2'b01; idle(2); btn = 2'b00; idle(3);
    btn = 2'b01; idle(2); btn = 2'b00; idle(6);
    rd(12'hF00);
    check("glitch_level", 64'(q_io), 64'h0);
    btn = 2'b01; idle(8);
    rd(12'hF00);
    check("held_level", 64'(q_io), 64'h1);
    rd(12'hF01);
    check("press_first", 64'(q_io), 64'h1);
    rd(12'hF01);
    check("press_cleared", 64'(q_io), 64'h0);
    btn = 2'b00; idle(8);

    // Debounced rise lands on the same edge as the clearing read.
    btn = 2'b01; idle(5);
    rd(12'hF01);
    check("press_race_rd", 64'(q_io), 64'h0);
    rd(12'hF01);
    check("press_race_kept", 64'(q_io), 64'h1);

    // Commit disabled: active copies freeze while frames still count.
    wr(12'hF03, 32'h0);
    wr(12'hF10, 32'h011);
    wr(12'hF11, 32'h022);
    pulse(); pulse(); pulse();
    check("frozen_x0", 64'(sprite_x_flat[9:0]), 64'h3FF);
    rd(12'hF02);
    check("frame_cnt_4", 64'(q_io), 64'h4);
    wr(12'hF03, 32'h1);
    pulse();
    check("unfrozen_x0", 64'(sprite_x_flat[9:0]), 64'h011);
    rd(12'hF02);
    check("frame_cnt_5", 64'(q_io), 64'h5);

    // Store coincident with the frame edge commits one frame later.
    address_dmem = 12'hF10; data = 32'h0AA; wren = 1'b1; screen_end = 1'b1;
    tick();
    wren = 1'b0; screen_end = 1'b0;
    tick();
    check("coincident_old", 64'(sprite_x_flat[9:0]), 64'h011);
    pulse();
    check("coincident_new", 64'(sprite_x_flat[9:0]), 64'h0AA);

    // Simultaneous load/store returns the pre-store value.
    address_dmem = 12'hF11; data = 32'h0BB; wren = 1'b1; ren = 1'b1;
    tick();
    wren = 1'b0; ren = 1'b0;
    check("rw_pre_value", 64'(q_io), 64'h022);

    // A held strobe counts a single frame.
    screen_end = 1'b1; idle(3); screen_end = 1'b0; tick();
    check("held_commit_y0", 64'(sprite_y_flat[9:0]), 64'h0BB);
    rd(12'hF02);
    check("frame_cnt_8", 64'(q_io), 64'h8);

    // Reset mid-sequence drops pending shadow values.
    wr(12'hF14, 32'h155);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    check("midrst_x", 64'(sprite_x_flat), 64'h0);
    check("midrst_y", 64'(sprite_y_flat), 64'h0);
    check("midrst_q", 64'(q_io), 64'h0);
    pulse();
    check("post_rst_commit", 64'(sprite_x_flat), 64'h0);
    rd(12'hF03);
    check("ctrl_reset_val", 64'(q_io), 64'h1);
    rd(12'hF14);
    check("shadow_lost", 64'(q_io), 64'h0);
    idle(2);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
